// File: rtl/vx_lsu_mem_responder_pkg.sv
// Shared defaults and helpers for the LSU memory responder slice.
//   NUM_LANES_DEF / DATA_SIZE_DEF / ADDR_WIDTH_DEF / TAG_WIDTH_DEF : default geometry
//   idx_bits(n) : width of a lane index for n lanes (never zero)
package vx_lsu_mem_responder_pkg;

  localparam int unsigned NUM_LANES_DEF  = 4;
  localparam int unsigned DATA_SIZE_DEF  = 4;
  localparam int unsigned ADDR_WIDTH_DEF = 10;
  localparam int unsigned TAG_WIDTH_DEF  = 8;

  function automatic int unsigned idx_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vx_lsu_mem_responder_priority_encoder.sv
// Lowest-index-first priority encoder.
//   data_in   : request vector
//   index     : index of the lowest set bit (0 when none)
//   valid_out : at least one bit of data_in is set
module vx_lsu_mem_responder_priority_encoder
  import vx_lsu_mem_responder_pkg::*;
#(
  parameter int unsigned N    = 4,
  parameter int unsigned IDXW = idx_bits(N)
) (
  input  logic [N-1:0]    data_in,
  output logic [IDXW-1:0] index,
  output logic            valid_out
);

  always_comb begin
    index     = '0;
    valid_out = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (data_in[i] && !valid_out) begin
        index     = IDXW'(i);
        valid_out = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vx_lsu_mem_responder.sv
// Multi-lane LSU memory responder backed by a byte-enabled register array.
// One request is taken in IDLE, its active lanes are served one per cycle
// (lowest index first) in ACCESS, and reads are returned in RESP.
//   clk, reset                      : clock, async active-high reset
//   req_valid/req_ready             : request handshake (ready only in IDLE)
//   req_rw/mask/byteen/addr/data/tag: request payload (rw: 1 = write)
//   rsp_valid/rsp_ready             : read response handshake
//   rsp_mask/rsp_data/rsp_tag       : read response payload
module vx_lsu_mem_responder
  import vx_lsu_mem_responder_pkg::*;
#(
  parameter int unsigned NUM_LANES  = NUM_LANES_DEF,
  parameter int unsigned DATA_SIZE  = DATA_SIZE_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned TAG_WIDTH  = TAG_WIDTH_DEF
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic                              req_rw,
  input  logic [NUM_LANES-1:0]              req_mask,
  input  logic [NUM_LANES*DATA_SIZE-1:0]    req_byteen,
  input  logic [NUM_LANES*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_LANES*DATA_SIZE*8-1:0]  req_data,
  input  logic [TAG_WIDTH-1:0]              req_tag,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [NUM_LANES-1:0]              rsp_mask,
  output logic [NUM_LANES*DATA_SIZE*8-1:0]  rsp_data,
  output logic [TAG_WIDTH-1:0]              rsp_tag
);

  localparam int unsigned WORD_W    = DATA_SIZE * 8;
  localparam int unsigned DEPTH     = 1 << ADDR_WIDTH;
  localparam int unsigned LANE_BITS = idx_bits(NUM_LANES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state, state_n;

  logic                             rw_r;
  logic [NUM_LANES-1:0]             mask_r;
  logic [NUM_LANES-1:0]             pending_r;
  logic [NUM_LANES*DATA_SIZE-1:0]   byteen_r;
  logic [NUM_LANES*ADDR_WIDTH-1:0]  addr_r;
  logic [NUM_LANES*WORD_W-1:0]      data_r;
  logic [TAG_WIDTH-1:0]             tag_r;
  logic [NUM_LANES*WORD_W-1:0]      rdata_r;

  logic [WORD_W-1:0] mem [DEPTH];

  logic                  accept;
  logic                  serve;
  logic [LANE_BITS-1:0]  lane;
  logic                  lane_valid;
  logic [NUM_LANES-1:0]  pending_clr;
  logic [ADDR_WIDTH-1:0] lane_addr;
  logic [DATA_SIZE-1:0]  lane_byteen;
  logic [WORD_W-1:0]     lane_wdata;

  vx_lsu_mem_responder_priority_encoder #(
    .N    (NUM_LANES),
    .IDXW (LANE_BITS)
  ) u_lane_sel (
    .data_in   (pending_r),
    .index     (lane),
    .valid_out (lane_valid)
  );

  assign accept      = req_valid && req_ready;
  assign serve       = (state == ACCESS) && lane_valid;
  assign pending_clr = pending_r & ~(NUM_LANES'(1) << lane);

  // Selected lane's latched fields; constant-index compare keeps the mux lint-clean.
  always_comb begin
    lane_addr   = '0;
    lane_byteen = '0;
    lane_wdata  = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      if (LANE_BITS'(i) == lane) begin
        lane_addr   = addr_r[i*ADDR_WIDTH +: ADDR_WIDTH];
        lane_byteen = byteen_r[i*DATA_SIZE +: DATA_SIZE];
        lane_wdata  = data_r[i*WORD_W +: WORD_W];
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_mask != '0) state_n = ACCESS;
          else if (!req_rw)   state_n = RESP;
        end
      end
      ACCESS: begin
        if (pending_clr == '0) state_n = rw_r ? IDLE : RESP;
      end
      RESP: begin
        if (rsp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    req_ready = (state == IDLE) && !reset;
    rsp_valid = (state == RESP);
    rsp_mask  = mask_r;
    rsp_tag   = tag_r;
    rsp_data  = rdata_r;
  end

  // Request latch, pending tracking and read-slot capture.
  // Response slots are cleared on acceptance so inactive lanes read back as zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rw_r      <= 1'b0;
      mask_r    <= '0;
      pending_r <= '0;
      byteen_r  <= '0;
      addr_r    <= '0;
      data_r    <= '0;
      tag_r     <= '0;
      rdata_r   <= '0;
    end else if (accept) begin
      rw_r      <= req_rw;
      mask_r    <= req_mask;
      pending_r <= req_mask;
      byteen_r  <= req_byteen;
      addr_r    <= req_addr;
      data_r    <= req_data;
      tag_r     <= req_tag;
      rdata_r   <= '0;
    end else if (serve) begin
      pending_r <= pending_clr;
      if (!rw_r) begin
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
          if (LANE_BITS'(i) == lane) rdata_r[i*WORD_W +: WORD_W] <= mem[lane_addr];
        end
      end
    end
  end

  // Storage is intentionally not reset; an aborted write keeps lanes already served.
  always_ff @(posedge clk) begin
    if (serve && rw_r) begin
      for (int unsigned b = 0; b < DATA_SIZE; b++) begin
        if (lane_byteen[b]) mem[lane_addr][b*8 +: 8] <= lane_wdata[b*8 +: 8];
      end
    end
  end

endmodule

// File: doc/vx_lsu_mem_responder.md
VX_LSU_MEM_RESPONDER -- requirements
Module: VX_lsu_mem_responder

Interface
REQ-001 SHALL have parameter NUM_LANES, default 4: lanes per request.
REQ-002 SHALL have parameter DATA_SIZE, default 4: bytes per lane word.
REQ-003 SHALL have parameter ADDR_WIDTH, default 10: word address width; storage depth is 2^ADDR_WIDTH words.
REQ-004 SHALL have parameter TAG_WIDTH, default 8: opaque request tag width.
REQ-005 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have ports req_valid (input, 1) and req_ready (output, 1): request handshake.
REQ-008 SHALL have port req_rw, input, 1: 1 = write, 0 = read.
REQ-009 SHALL have port req_mask, input, NUM_LANES: per-lane active bit.
REQ-010 SHALL have port req_byteen, input, NUM_LANES*DATA_SIZE: per-lane byte enables, writes only.
REQ-011 SHALL have port req_addr, input, NUM_LANES*ADDR_WIDTH: per-lane word address.
REQ-012 SHALL have port req_data, input, NUM_LANES*DATA_SIZE*8: per-lane write data.
REQ-013 SHALL have port req_tag, input, TAG_WIDTH: returned unchanged on the response.
REQ-014 SHALL have ports rsp_valid (output, 1) and rsp_ready (input, 1): response handshake.
REQ-015 SHALL have ports rsp_mask (output, NUM_LANES), rsp_data (output, NUM_LANES*DATA_SIZE*8) and rsp_tag (output, TAG_WIDTH): read response.

Function
REQ-016 SHALL implement a three-state FSM: IDLE, ACCESS, RESP.
REQ-017 SHALL drive req_ready=1 only in IDLE; a request is accepted on req_valid && req_ready.
REQ-018 SHALL latch rw, mask, byteen, addr, data and tag on acceptance, with a pending-lane vector initialised to req_mask.
REQ-019 SHALL go IDLE->ACCESS on acceptance with a nonzero mask; a read with zero mask SHALL go directly to RESP, and a write with zero mask SHALL stay in IDLE.
REQ-020 SHALL in ACCESS serve exactly one lane per cycle: the lowest-index pending lane, which is then cleared from the pending vector.
REQ-021 SHALL on a write lane update only the bytes whose byteen bit is set; on a read lane it SHALL capture the full word into that lane's response slot.
REQ-022 SHALL leave ACCESS after the last pending lane: write -> IDLE, read -> RESP.
REQ-023 SHALL apply lanes in order for writes to a shared address, so the highest-index lane wins per byte.
REQ-024 SHALL make reads within one request see writes only from earlier requests.
REQ-025 SHALL hold rsp_valid=1 in RESP with rsp_mask = latched mask and rsp_tag = latched tag; inactive-lane rsp_data SHALL be zero.
REQ-026 SHALL keep all rsp_* outputs stable until rsp_ready, then go RESP->IDLE.
REQ-027 SHALL meet this latency: a read with k>=1 active lanes accepted at cycle T asserts rsp_valid at T+k+1; a write with k lanes re-asserts req_ready at T+k+1.
REQ-028 SHALL generate no response for writes.

Reset
REQ-029 SHALL on reset force state IDLE and clear the pending vector, rsp_valid, rsp_mask, rsp_tag and rsp_data to 0.
REQ-030 SHALL hold req_ready=0 while reset is asserted and 1 from the first cycle after deassertion.
REQ-031 SHALL on reset mid-operation abort the request: bytes already written remain, unserved lanes are dropped, and no response is issued.
REQ-032 SHALL not reset storage contents.

Structure
REQ-033 SHALL define the FSM state enum locally; lane/tag widths used by the core SHALL come from VX_gpu_pkg / VX_define.vh.
REQ-034 SHALL use VX_priority_encoder as its one sub-module to select the lowest pending lane.
REQ-035 SHALL infer storage as a single-port, byte-enabled register array.

Verification
REQ-036 SHALL cover: write lanes 0-3 addr 0..3 data 0x11111111..0x44444444 byteen 0xF each; read same addresses -> rsp_data equals written words, rsp_valid at T+5, tag echoed.
REQ-037 SHALL cover: write addr 7 = 0xAABBCCDD, then write addr 7 byteen 0x3 data 0x00001122, then read -> 0xAABB1122.
REQ-038 SHALL cover: a single write with lanes 0 and 2 both at addr 5, data 0x1 and 0x2 -> a later read of addr 5 returns 0x2.
REQ-039 SHALL cover: a read with mask 0000 and tag 0x5A -> rsp_valid at T+1, rsp_mask 0, tag 0x5A; a write with mask 0000 -> req_ready stays 1, no response.
REQ-040 SHALL cover: a read with mask 0101 and rsp_ready held 0 for 10 cycles -> rsp_* stable and req_ready 0 throughout; IDLE one cycle after the handshake.
REQ-041 SHALL cover: reset asserted during ACCESS of a 4-lane write after 2 lanes -> lanes 0-1 stored, lanes 2-3 unchanged, rsp_valid 0, req_ready 1 after release.
